// File: rtl/hub75_panel_receiver.sv
// HUB75 panel-side receiver: shifts column data, latches rows,
// times display-enable and emits one record per displayed row.
module hub75_panel_receiver #(
  parameter int segments   = 1,
  parameter int rows       = 8,
  parameter int columns    = 32,
  parameter int countwidth = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              oclk,
  input  logic                              lat,
  input  logic                              oe,
  input  logic [$clog2(rows)-1:0]           row,
  input  logic [3*segments-1:0]             rgb,
  output logic                              out_valid,
  output logic [$clog2(rows)-1:0]           out_row,
  output logic [columns*3*segments-1:0]     out_data,
  output logic [countwidth-1:0]             out_on_cycles,
  output logic                              shift_error,
  output logic                              overlap_error
);

  localparam int RW  = $clog2(rows);
  localparam int CW  = 3 * segments;
  localparam int SW  = columns * CW;
  localparam int SCW = $clog2(columns + 2);

  localparam logic [SCW-1:0]        COLS    = SCW'(columns);
  localparam logic [SCW-1:0]        COLS_P1 = SCW'(columns + 1);
  localparam logic [countwidth-1:0] ON_MAX  = '1;

  logic          oclk_q, oclk_qq;
  logic          lat_q, lat_qq;
  logic          oe_q, oe_qq;
  logic [RW-1:0] row_q;
  logic [CW-1:0] rgb_q;

  logic [SW-1:0]         sr_q, sr_d;
  logic [SCW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [SW-1:0]         ldata_q, ldata_d;
  logic [RW-1:0]         lrow_q, lrow_d;
  logic [countwidth-1:0] on_q, on_d;
  logic                  valid_q, valid_d;
  logic [RW-1:0]         orow_q, orow_d;
  logic [SW-1:0]         odata_q, odata_d;
  logic [countwidth-1:0] oon_q, oon_d;
  logic                  serr_q, serr_d;
  logic                  oerr_q, oerr_d;

  logic sh_rise, lat_rise, oe_rise, oe_fall;

  assign sh_rise  = oclk_q & ~oclk_qq;
  assign lat_rise = lat_q & ~lat_qq;
  assign oe_rise  = oe_q & ~oe_qq;
  assign oe_fall  = ~oe_q & oe_qq;

  // Input registration and one-deep history for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oclk_q  <= 1'b0;
      oclk_qq <= 1'b0;
      lat_q   <= 1'b0;
      lat_qq  <= 1'b0;
      oe_q    <= 1'b0;
      oe_qq   <= 1'b0;
      row_q   <= '0;
      rgb_q   <= '0;
    end else begin
      oclk_q  <= oclk;
      oclk_qq <= oclk_q;
      lat_q   <= lat;
      lat_qq  <= lat_q;
      oe_q    <= oe;
      oe_qq   <= oe_q;
      row_q   <= row;
      rgb_q   <= rgb;
    end
  end

  // Shift, latch, on-time and record next-state logic
  always_comb begin
    sr_d    = sr_q;
    cnt_inc = cnt_q;
    ldata_d = ldata_q;
    lrow_d  = lrow_q;
    serr_d  = serr_q;
    oerr_d  = oerr_q;
    on_d    = on_q;
    valid_d = oe_fall;
    orow_d  = orow_q;
    odata_d = odata_q;
    oon_d   = oon_q;

    if (sh_rise) begin
      sr_d = {rgb_q, sr_q[SW-1:CW]};
      if (cnt_q != COLS_P1) cnt_inc = cnt_q + 1'b1;
    end
    cnt_d = cnt_inc;

    if (lat_rise) begin
      ldata_d = sr_d;
      lrow_d  = row_q;
      cnt_d   = '0;
      if (cnt_inc != COLS) serr_d = 1'b1;
      if (oe_q) oerr_d = 1'b1;
    end

    if (oe_rise) begin
      on_d = {{(countwidth-1){1'b0}}, 1'b1};
    end else if (oe_q && on_q != ON_MAX) begin
      on_d = on_q + 1'b1;
    end

    if (oe_fall) begin
      orow_d  = lrow_q;
      odata_d = ldata_q;
      oon_d   = on_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      ldata_q <= '0;
      lrow_q  <= '0;
      on_q    <= '0;
      valid_q <= 1'b0;
      orow_q  <= '0;
      odata_q <= '0;
      oon_q   <= '0;
      serr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ldata_q <= ldata_d;
      lrow_q  <= lrow_d;
      on_q    <= on_d;
      valid_q <= valid_d;
      orow_q  <= orow_d;
      odata_q <= odata_d;
      oon_q   <= oon_d;
      serr_q  <= serr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_row       = orow_q;
  assign out_data      = odata_q;
  assign out_on_cycles = oon_q;
  assign shift_error   = serr_q;
  assign overlap_error = oerr_q;

endmodule

// File: tb/tb_hub75_panel_receiver.sv
// Bench for hub75_panel_receiver: randomized panel traffic,
// reference model with a record scoreboard and async-reset checks.
module tb_hub75_panel_receiver;

  localparam int COLS = 32;
  localparam int SW   = 96;

  logic          clk = 1'b0;
  logic          rst;
  logic          oclk, lat, oe;
  logic [2:0]    row, rgb;

  logic          v1, v2;
  logic [2:0]    o_row, o_row2;
  logic [SW-1:0] o_data, o_data2;
  logic [15:0]   o_on;
  logic [3:0]    o_on2;
  logic          serr, oerr, serr2, oerr2;

  hub75_panel_receiver #(.segments(1), .rows(8), .columns(32), .countwidth(16)) u_dut (
    .clk(clk), .rst(rst), .oclk(oclk), .lat(lat), .oe(oe), .row(row), .rgb(rgb),
    .out_valid(v1), .out_row(o_row), .out_data(o_data), .out_on_cycles(o_on),
    .shift_error(serr), .overlap_error(oerr)
  );

  hub75_panel_receiver #(.segments(1), .rows(8), .columns(32), .countwidth(4)) u_sat (
    .clk(clk), .rst(rst), .oclk(oclk), .lat(lat), .oe(oe), .row(row), .rgb(rgb),
    .out_valid(v2), .out_row(o_row2), .out_data(o_data2), .out_on_cycles(o_on2),
    .shift_error(serr2), .overlap_error(oerr2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    row;
    logic [SW-1:0] data;
    int            on;
  } rec_t;

  rec_t exq[$];
  int   satq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  logic [2:0]    shq[$];
  logic [2:0]    m_row;
  logic [SW-1:0] m_data;
  int            m_cnt;
  logic          m_serr, m_oerr;
  int            on_run;
  int            oe_left;
  logic          oclk_p, lat_p, oe_p;
  logic [2:0]    row_v;

  task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    shq.delete();
    m_row  = '0;
    m_data = '0;
    m_cnt  = 0;
    m_serr = 1'b0;
    m_oerr = 1'b0;
    on_run = 0;
  endtask

  // one clock of stimulus, applied at the falling edge, with model update
  task automatic tick(input logic ck, input logic lt, input logic [2:0] c);
    logic oe_n;
    rec_t e;
    @(negedge clk);
    oe_n = (oe_left > 0);
    if (oe_left > 0) oe_left--;
    if (oe_p && !oe_n) begin
      e.row  = m_row;
      e.data = m_data;
      e.on   = on_run;
      exq.push_back(e);
      satq.push_back(on_run > 15 ? 15 : on_run);
    end
    if (oe_n) on_run = oe_p ? on_run + 1 : 1;
    if (ck && !oclk_p) begin
      shq.push_back(c);
      if (shq.size() > COLS) void'(shq.pop_front());
      m_cnt++;
    end
    if (lt && !lat_p) begin
      m_data = '0;
      for (int k = 0; k < shq.size(); k++)
        m_data[(COLS - shq.size() + k)*3 +: 3] = shq[k];
      m_row = row_v;
      if (m_cnt != COLS) m_serr = 1'b1;
      if (oe_n) m_oerr = 1'b1;
      m_cnt = 0;
    end
    oclk   = ck;
    lat    = lt;
    oe     = oe_n;
    rgb    = c;
    row    = row_v;
    oclk_p = ck;
    lat_p  = lt;
    oe_p   = oe_n;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'd0);
  endtask

  task automatic pulse(input logic [2:0] c);
    tick(1'b1, 1'b0, c);
    tick(1'b0, 1'b0, c);
  endtask

  task automatic shift_rand(input int n);
    for (int i = 0; i < n; i++) pulse(3'($urandom_range(0, 7)));
  endtask

  task automatic latch(input logic [2:0] r);
    row_v = r;
    tick(1'b0, 1'b1, 3'd0);
    tick(1'b0, 1'b0, 3'd0);
  endtask

  task automatic wait_oe();
    while (oe_left > 0) tick(1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 3'd0);
  endtask

  task automatic chk_flags(input string nm);
    idle(3);
    chk({nm, "_shift_error"}, SW'(serr), SW'(m_serr));
    chk({nm, "_overlap_error"}, SW'(oerr), SW'(m_oerr));
  endtask

  // scoreboard monitor: pops one expected record per valid pulse
  always @(negedge clk) begin
    rec_t e;
    int   s;
    if (v1) begin
      if (exq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rec_unexpected: got valid row %0d expected none", o_row);
      end else begin
        e = exq.pop_front();
        chk("rec_row", SW'(o_row), SW'(e.row));
        chk("rec_data", o_data, e.data);
        chk("rec_on_cycles", SW'(o_on), SW'(e.on));
      end
    end
    if (v2) begin
      if (satq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sat_unexpected: got valid expected none");
      end else begin
        s = satq.pop_front();
        chk("sat_on_cycles", SW'(o_on2), SW'(s));
      end
    end
  end

  initial begin
    rst = 1'b0;
    oclk = 1'b0; lat = 1'b0; oe = 1'b0; row = '0; rgb = '0;
    oclk_p = 1'b0; lat_p = 1'b0; oe_p = 1'b0;
    row_v = '0;
    oe_left = 0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("reset_valid", SW'(v1), '0);
    chk("reset_row", SW'(o_row), '0);
    chk("reset_data", o_data, '0);
    chk("reset_on", SW'(o_on), '0);
    chk("reset_flags", SW'({serr, oerr}), '0);
    rst = 1'b1;
    idle(2);

    // single lit pixel in column 0, row 0, 10 cycles on
    row_v = 3'd0;
    pulse(3'b100);
    for (int i = 1; i < COLS; i++) pulse(3'b000);
    latch(3'd0);
    oe_left = 10;
    wait_oe();
    idle(3);
    chk("pixel_record_seen", SW'(exq.size()), '0);

    // column ordering
    for (int i = 0; i < COLS; i++) pulse(3'(i % 8));
    latch(3'd5);
    oe_left = 7;
    wait_oe();
    idle(3);

    // random rows and on-times
    for (int r = 0; r < 4; r++) begin
      shift_rand(COLS);
      latch(3'($urandom_range(0, 7)));
      oe_left = $urandom_range(1, 40);
      wait_oe();
      idle($urandom_range(1, 4));
    end
    chk_flags("clean");

    // binary-weighted on-times with the next row loaded while lit
    shift_rand(COLS);
    latch(3'd0);
    for (int b = 0; b < 10; b++) begin
      oe_left = 1 << b;
      shift_rand(COLS);
      wait_oe();
      idle(1);
      latch(3'((b + 1) % 8));
    end
    oe_left = 20;
    wait_oe();
    idle(3);
    chk_flags("bcm");

    // latch while lit
    shift_rand(COLS);
    latch(3'd2);
    shift_rand(COLS);
    oe_left = 20;
    idle(3);
    latch(3'd3);
    wait_oe();
    chk_flags("overlap");

    // short row then a correct row: error stays
    shift_rand(COLS - 1);
    latch(3'd4);
    chk_flags("short");
    shift_rand(COLS);
    latch(3'd6);
    oe_left = 5;
    wait_oe();
    chk_flags("short_sticky");

    // async reset halfway through a row
    shift_rand(16);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_valid", SW'(v1), '0);
    chk("arst_row", SW'(o_row), '0);
    chk("arst_data", o_data, '0);
    chk("arst_on", SW'(o_on), '0);
    chk("arst_flags", SW'({serr, oerr}), '0);
    exq.delete();
    satq.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    shift_rand(COLS);
    latch(3'd7);
    oe_left = 12;
    wait_oe();
    chk_flags("post_reset");

    idle(6);
    chk("pending_records", SW'(exq.size()), '0);
    chk("pending_sat_records", SW'(satq.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
